cu_sequencer: RTL

Program-driven control unit that sits directly upstream of the 16x8 register bank. It produces every register-bank control each cycle: input-mux select, write enable, register address, output-mux select and the 8-bit constant. It also drives the ALU operation select.
A 16-word internal program memory is loaded while idle, then executed on a start pulse until a HALT instruction.

---
 rtl/cu_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cu_sequencer.sv
// Program-driven sequencer for the 16x8 register bank: runs a 16-word program
// as FETCH/EXEC pairs and drives bank, ALU and constant controls each cycle.
module cu_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int IW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          prog_we,
    input  logic [3:0]    prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic          ALUzero,
    output logic [7:0]    CUconst,
    output logic [2:0]    InMuxAdd,
    output logic          WE,
    output logic [3:0]    RegAdd,
    output logic [3:0]    OutMuxAdd,
    output logic [2:0]    ALUsel,
    output logic          busy,
    output logic          done,
    output logic [3:0]    pc,
    output logic [7:0]    instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } stateT;

    localparam logic [2:0] opMovi = 3'b000;
    localparam logic [2:0] opLda  = 3'b001;
    localparam logic [2:0] opLdb  = 3'b010;
    localparam logic [2:0] opAlu  = 3'b011;
    localparam logic [2:0] opMov  = 3'b100;
    localparam logic [2:0] opJnz  = 3'b101;
    localparam logic [2:0] opNop  = 3'b110;
    localparam logic [2:0] opHalt = 3'b111;

    stateT         state;
    stateT         nextState;
    logic [IW-1:0] progMem [PROG_DEPTH];
    logic [IW-1:0] ir;
    logic [2:0]    opcode;
    logic [3:0]    pcNext;
    logic          runReq;
    logic          unusedIrBit;

    assign opcode      = ir[15:13];
    assign unusedIrBit = ir[12];
    assign runReq      = start && (state == IDLE || state == HALT);

    function automatic logic [7:0] satInc(input logic [7:0] val);
        satInc = (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    // Program memory has no reset so a loaded program survives a reset pulse
    always_ff @(posedge clk) begin
        if (reset && state == IDLE && prog_we) begin
            progMem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = FETCH;
            FETCH:   nextState = EXEC;
            EXEC:    nextState = (opcode == opHalt) ? HALT : FETCH;
            HALT:    if (start) nextState = FETCH;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        pcNext = pc + 4'd1;
        if (opcode == opJnz && !ALUzero) begin
            pcNext = ir[3:0];
        end else if (opcode == opHalt) begin
            pcNext = pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= 4'd0;
            ir          <= '0;
            instr_count <= 8'd0;
        end else if (runReq) begin
            pc          <= 4'd0;
            instr_count <= 8'd0;
        end else if (state == FETCH) begin
            ir <= progMem[pc];
        end else if (state == EXEC) begin
            pc          <= pcNext;
            instr_count <= satInc(instr_count);
        end
    end

    // Bank controls are live only in EXEC; every other cycle they rest at zero
    always_comb begin
        CUconst   = 8'd0;
        InMuxAdd  = 3'd0;
        WE        = 1'b0;
        RegAdd    = 4'd0;
        OutMuxAdd = 4'd0;
        ALUsel    = 3'd0;
        if (state == EXEC) begin
            case (opcode)
                opMovi: begin
                    InMuxAdd = 3'd2;
                    CUconst  = ir[7:0];
                    RegAdd   = ir[11:8];
                    WE       = 1'b1;
                end
                opLda: begin
                    InMuxAdd = 3'd0;
                    RegAdd   = ir[11:8];
                    WE       = 1'b1;
                end
                opLdb: begin
                    InMuxAdd = 3'd1;
                    RegAdd   = ir[11:8];
                    WE       = 1'b1;
                end
                opAlu: begin
                    ALUsel   = ir[6:4];
                    InMuxAdd = 3'd3;
                    RegAdd   = ir[11:8];
                    WE       = 1'b1;
                end
                opMov: begin
                    InMuxAdd  = 3'd4;
                    OutMuxAdd = ir[3:0];
                    RegAdd    = ir[11:8];
                    WE        = 1'b1;
                end
                opJnz, opNop, opHalt: WE = 1'b0;
                default: WE = 1'b0;
            endcase
        end
    end

    assign busy = (state == FETCH) || (state == EXEC);
    assign done = (state == HALT);

endmodule
